// File: rtl/display_scan_mux_pkg.sv
// display_scan_mux_pkg
//   Shared definitions for the multiplexed 7-segment scanner: nibble width
//   and the slot FSM state encoding used by the scanner and its neighbours.
package display_scan_mux_pkg;

  localparam int NIBBLE_W = 4;

  // Slot phase: BLANK is the dead-time gap, DRIVE lights the selected digit.
  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } slot_state_t;

endpackage

// File: rtl/display_scan_mux_tick_gen.sv
// scan_tick_gen
//   Slot prescaler. Counts 0..PRESCALE-1 and wraps.
//   Ports:
//     clk         in   system clock, rising edge
//     reset       in   asynchronous, active-high
//     o_cnt_nxt   out  count value for the next cycle (0 after a wrap)
//     o_slot_end  out  strobe, high in the last cycle of every slot
//   The next count is exported so that the scanner can register its outputs
//   for the coming cycle and show them aligned with the slot they belong to.
module scan_tick_gen #(
  parameter int PRESCALE = 50000,
  parameter int CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] o_cnt_nxt,
  output logic             o_slot_end
);

  logic [CNT_W-1:0] r_cnt;

  assign o_slot_end = (r_cnt == CNT_W'(PRESCALE - 1));
  assign o_cnt_nxt  = o_slot_end ? '0 : (r_cnt + CNT_W'(1));

  // Slot counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= o_cnt_nxt;
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// display_scan_mux
//   Time-multiplexed scanner for a DIGITS-wide 7-segment display. A shadow
//   copy of the packed value is presented one nibble per slot, with a blanked
//   dead time at the start of each slot, optional leading-zero suppression,
//   and a req/ack load that only takes effect at frame boundaries.
//   Ports:
//     clk, reset   clock (rising) and asynchronous active-high reset
//     value_in     packed nibbles, [3:0] = digit 0 (rightmost)
//     dp_in        decimal points, bit i = digit i
//     load_req     level request, captured at the next frame boundary
//     load_ack     one-cycle pulse in the cycle after the capture
//     lz_blank     1 = suppress leading zeros (digit 0 always shown)
//     bcd_out      nibble of the current digit
//     dp_out       decimal point of the current digit, active-high
//     digit_en     one-hot digit enable, active-low when EN_ACTIVE_LOW=1
//   All outputs are registered. Their next values are computed from the
//   next count/index/shadow so each output lines up with its own slot cycle.
module display_scan_mux
  import display_scan_mux_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int PRESCALE      = 50000,
  parameter int DEAD          = 500,
  parameter int EN_ACTIVE_LOW = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NIBBLE_W*DIGITS-1:0] value_in,
  input  logic [DIGITS-1:0]          dp_in,
  input  logic                       load_req,
  output logic                       load_ack,
  input  logic                       lz_blank,
  output logic [NIBBLE_W-1:0]        bcd_out,
  output logic                       dp_out,
  output logic [DIGITS-1:0]          digit_en
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] EN_IDLE = (EN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Nibble of digit idx within a packed value.
  function automatic logic [NIBBLE_W-1:0] nibble_at(
    input logic [NIBBLE_W*DIGITS-1:0] val,
    input logic [IDX_W-1:0]           idx
  );
    logic [NIBBLE_W-1:0] nib;
    nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = (IDX_W'(i) == idx) ? val[i*NIBBLE_W +: NIBBLE_W] : nib;
    end
    return nib;
  endfunction

  // True when digit idx (>0) and every digit to its left hold zero.
  function automatic logic lz_hidden(
    input logic [NIBBLE_W*DIGITS-1:0] val,
    input logic [IDX_W-1:0]           idx
  );
    logic all_zero;
    logic hidden;
    all_zero = 1'b1;
    hidden   = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero && (val[i*NIBBLE_W +: NIBBLE_W] == '0);
      hidden   = (IDX_W'(i) == idx) ? all_zero : hidden;
    end
    return hidden;
  endfunction

  logic [CNT_W-1:0]           w_cnt_nxt;
  logic                       w_slot_end;
  logic                       w_boundary;
  logic                       w_load;
  logic                       w_idx_last;
  logic [IDX_W-1:0]           w_idx_nxt;
  logic [NIBBLE_W*DIGITS-1:0] w_val_nxt;
  logic [DIGITS-1:0]          w_dp_nxt;
  slot_state_t                w_state_nxt;
  logic                       w_hidden;
  logic                       w_show;
  logic [DIGITS-1:0]          w_onehot;
  logic [DIGITS-1:0]          w_en_nxt;
  logic                       w_dp_out_nxt;
  logic [NIBBLE_W-1:0]        w_bcd_nxt;

  slot_state_t                r_state;
  logic [IDX_W-1:0]           r_idx;
  logic [NIBBLE_W*DIGITS-1:0] r_shadow_val;
  logic [DIGITS-1:0]          r_shadow_dp;
  logic [NIBBLE_W-1:0]        r_bcd;
  logic                       r_dp;
  logic [DIGITS-1:0]          r_en;
  logic                       r_ack;

  scan_tick_gen #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .o_cnt_nxt  (w_cnt_nxt),
    .o_slot_end (w_slot_end)
  );

  // Frame boundary: last cycle of the last digit's slot.
  assign w_idx_last = (r_idx == IDX_W'(DIGITS - 1));
  assign w_boundary = w_slot_end && w_idx_last;
  assign w_load     = w_boundary && load_req;

  // Next digit index and next shadow contents.
  always_comb begin
    w_idx_nxt = r_idx;
    w_val_nxt = r_shadow_val;
    w_dp_nxt  = r_shadow_dp;
    if (w_slot_end) begin
      w_idx_nxt = w_idx_last ? '0 : (r_idx + IDX_W'(1));
    end else begin
      w_idx_nxt = r_idx;
    end
    if (w_load) begin
      w_val_nxt = value_in;
      w_dp_nxt  = dp_in;
    end else begin
      w_val_nxt = r_shadow_val;
      w_dp_nxt  = r_shadow_dp;
    end
  end

  // Slot FSM next state, decided by where the next count falls.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BLANK: w_state_nxt = (w_cnt_nxt >= CNT_W'(DEAD)) ? S_DRIVE : S_BLANK;
      S_DRIVE: w_state_nxt = (w_cnt_nxt <  CNT_W'(DEAD)) ? S_BLANK : S_DRIVE;
      default: w_state_nxt = S_BLANK;
    endcase
  end

  // Next output values for the coming cycle.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_onehot[i] = (IDX_W'(i) == w_idx_nxt);
    end
    w_hidden     = lz_blank && lz_hidden(w_val_nxt, w_idx_nxt);
    w_show       = (w_state_nxt == S_DRIVE) && !w_hidden;
    // XOR with the idle pattern flips the one-hot into active-low form.
    w_en_nxt     = w_show ? (w_onehot ^ EN_IDLE) : EN_IDLE;
    w_dp_out_nxt = w_show && w_dp_nxt[w_idx_nxt];
    // bcd_out only changes entering cnt==0, so it is steady through dead time.
    w_bcd_nxt    = w_slot_end ? nibble_at(w_val_nxt, w_idx_nxt) : r_bcd;
  end

  // Slot FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_BLANK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Digit index, shadow registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx        <= '0;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_bcd        <= '0;
      r_dp         <= 1'b0;
      r_en         <= EN_IDLE;
      r_ack        <= 1'b0;
    end else begin
      r_idx        <= w_idx_nxt;
      r_shadow_val <= w_val_nxt;
      r_shadow_dp  <= w_dp_nxt;
      r_bcd        <= w_bcd_nxt;
      r_dp         <= w_dp_out_nxt;
      r_en         <= w_en_nxt;
      r_ack        <= w_load;
    end
  end

  assign bcd_out  = r_bcd;
  assign dp_out   = r_dp;
  assign digit_en = r_en;
  assign load_ack = r_ack;

endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux
//   Self-checking bench for display_scan_mux (DIGITS=4, PRESCALE=8, DEAD=2,
//   active-low enables). A cycle-count reference model derives the expected
//   digit, slot phase, suppression and handshake from arithmetic on the
//   elapsed cycle number since reset release.
module tb_display_scan_mux;

  localparam int D     = 4;
  localparam int P     = 8;
  localparam int DT    = 2;
  localparam int FRAME = D * P;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load_req;
  logic        load_ack;
  logic        lz_blank;
  logic [3:0]  bcd_out;
  logic        dp_out;
  logic [3:0]  digit_en;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_t;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_ack;
  logic        m_lz;

  display_scan_mux #(
    .DIGITS        (D),
    .PRESCALE      (P),
    .DEAD          (DT),
    .EN_ACTIVE_LOW (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .value_in (value_in),
    .dp_in    (dp_in),
    .load_req (load_req),
    .load_ack (load_ack),
    .lz_blank (lz_blank),
    .bcd_out  (bcd_out),
    .dp_out   (dp_out),
    .digit_en (digit_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, m_t);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_en"},  16'(digit_en), 16'h000F);
    chk({tag, "_bcd"}, 16'(bcd_out),  16'h0000);
    chk({tag, "_dp"},  16'(dp_out),   16'h0000);
    chk({tag, "_ack"}, 16'(load_ack), 16'h0000);
  endtask

  // Expected outputs for the current cycle, from cycle number and shadow.
  task automatic check_model();
    int          c;
    int          idx;
    logic        sup;
    logic        act;
    logic [3:0]  en_e;
    logic [15:0] upper;
    c     = m_t % P;
    idx   = (m_t / P) % D;
    upper = m_val >> (4 * idx);
    sup   = m_lz && (idx != 0) && (upper == 16'h0000);
    act   = (c >= DT) && !sup;
    en_e  = act ? ~(4'b0001 << idx) : 4'b1111;
    chk("digit_en", 16'(digit_en), 16'(en_e));
    chk("bcd_out",  16'(bcd_out),  upper & 16'h000F);
    chk("dp_out",   16'(dp_out),   16'(act && m_dp[idx]));
    chk("load_ack", 16'(load_ack), 16'(m_ack));
  endtask

  // One clock: update model at the edge, check outputs half a cycle later.
  task automatic tick();
    @(posedge clk);
    if ((m_t % P == P - 1) && ((m_t / P) % D == D - 1) && load_req) begin
      m_val = value_in;
      m_dp  = dp_in;
      m_ack = 1'b1;
    end else begin
      m_ack = 1'b0;
    end
    m_lz = lz_blank;
    m_t++;
    @(negedge clk);
    check_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Raise load_req and drop it on seeing load_ack, bounded by two frames.
  task automatic load(input logic [15:0] v, input logic [3:0] d);
    bit ok;
    ok       = 1'b0;
    value_in = v;
    dp_in    = d;
    load_req = 1'b1;
    for (int i = 0; i < 2 * FRAME + 2 && !ok; i++) begin
      tick();
      if (load_ack === 1'b1) ok = 1'b1;
    end
    load_req = 1'b0;
    chk("load_ack_seen", 16'(ok), 16'h0001);
  endtask

  // Called at a falling edge: assert reset, check immediately, then release.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk_reset_outputs(tag);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_reset_outputs(tag);
    end
    reset = 1'b0;
    m_t   = 0;
    m_val = 16'h0000;
    m_dp  = 4'h0;
    m_ack = 1'b0;
    m_lz  = lz_blank;
    check_model();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acks;
    int          bad;
    logic [15:0] v;
    logic [3:0]  d;

    reset    = 1'b1;
    value_in = 16'h0000;
    dp_in    = 4'h0;
    load_req = 1'b0;
    lz_blank = 1'b0;
    m_t = 0; m_val = 16'h0; m_dp = 4'h0; m_ack = 1'b0; m_lz = 1'b0;

    // 1. reset state and first slot timing
    @(negedge clk);
    do_reset("t1_reset");
    run(2);
    chk("t1_first_drive", 16'(digit_en), 16'h000E);
    run(FRAME + 8);

    // 2. load 1234 with dp on digit 1
    load(16'h1234, 4'b0010);
    chk("t2_bcd_digit0", 16'(bcd_out), 16'h0004);
    run(FRAME);

    // 3. leading-zero suppression
    lz_blank = 1'b1;
    load(16'h0050, 4'b1111);
    run(FRAME);
    load(16'h0000, 4'b1111);
    bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (digit_en[3:1] !== 3'b111) bad++;
    end
    chk("t3_only_digit0", 16'(bad), 16'h0000);
    lz_blank = 1'b0;

    // 4. request raised mid-frame while 1234 is shown
    load(16'h1234, 4'b0000);
    run(11);
    load(16'hABCD, 4'b0101);
    run(FRAME);

    // 5. request held for three frames
    value_in = 16'h5A5A;
    dp_in    = 4'b1001;
    load_req = 1'b1;
    acks     = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (load_ack === 1'b1) acks++;
    end
    load_req = 1'b0;
    chk("t5_ack_count", 16'(acks), 16'h0003);
    run(FRAME);

    // Randomized loads, lz settings and request timing
    for (int k = 0; k < 20; k++) begin
      lz_blank = 1'($urandom_range(0, 1));
      v = 16'($urandom);
      v = v >> (4 * $urandom_range(0, 4));
      d = 4'($urandom);
      run($urandom_range(0, 40));
      load(v, d);
      run($urandom_range(FRAME / 2, FRAME));
    end

    // 6. reset mid-slot at cnt 5, idx 2
    lz_blank = 1'b0;
    load(16'h9876, 4'b0100);
    for (int i = 0; i < FRAME && !((m_t % P == 5) && ((m_t / P) % D == 2)); i++) tick();
    chk("t6_pre_en", 16'(digit_en), 16'h000B);
    do_reset("t6_reset");
    run(FRAME + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
